// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU.
// Single-cycle logic/arith/shift ops complete in one edge.
// MULT/MULTU use WIDTH shift-add iterations and DIV/DIVU use WIDTH restoring
// iterations, followed by one FIN cycle that applies signs and writes HI/LO.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_by_zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SLT   = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_MULT  = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t             r_state;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_acc;      // {hi/remainder, lo/multiplier/quotient}
    logic [WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
    logic               r_neg_lo;   // negate product / quotient at FIN
    logic               r_neg_hi;   // negate remainder at FIN
    logic               r_is_div;
    logic               r_b_zero;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dz;

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_result      = r_result;
    assign o_zero        = r_zero;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_div_by_zero = r_dz;

    // Operand preparation for the iterative unit.
    logic [SHW-1:0]   w_shamt;
    logic             w_signed_op;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_sign_diff;

    assign w_shamt     = i_b[SHW-1:0];
    assign w_signed_op = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_a_mag     = (w_signed_op && i_a[WIDTH-1]) ? ({WIDTH{1'b0}} - i_a) : i_a;
    assign w_b_mag     = (w_signed_op && i_b[WIDTH-1]) ? ({WIDTH{1'b0}} - i_b) : i_b;
    assign w_sign_diff = w_signed_op && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);

    // Single-cycle operation result; reserved and multi-cycle codes give zero.
    logic [WIDTH-1:0] w_alu;
    always_comb begin
        w_alu = {WIDTH{1'b0}};
        case (i_op)
            OP_AND:  w_alu = i_a & i_b;
            OP_OR:   w_alu = i_a | i_b;
            OP_ADD:  w_alu = i_a + i_b;
            OP_XOR:  w_alu = i_a ^ i_b;
            OP_SUB:  w_alu = i_a - i_b;
            OP_SRL:  w_alu = i_a >> w_shamt;
            OP_SLL:  w_alu = i_a << w_shamt;
            OP_NOR:  w_alu = ~(i_a | i_b);
            OP_SRA:  w_alu = $unsigned($signed(i_a) >>> w_shamt);
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: w_alu = {WIDTH{1'b0}};
        endcase
    end

    // One shift-add step: add multiplicand when multiplier LSB is set, shift right.
    logic [WIDTH-1:0]   w_mul_add;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    assign w_mul_add  = r_acc[0] ? r_opnd : {WIDTH{1'b0}};
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_mul_add};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // One restoring-division step: shift in next dividend bit, trial subtract.
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    // Sign correction applied in FIN; a zero divisor forces an all-ones quotient.
    logic [2*WIDTH-1:0] w_prod_neg;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;
    assign w_prod_neg = {(2*WIDTH){1'b0}} - r_acc;
    always_comb begin
        w_fin_hi = r_acc[2*WIDTH-1:WIDTH];
        w_fin_lo = r_acc[WIDTH-1:0];
        if (r_is_div) begin
            if (r_b_zero) begin
                w_fin_lo = {WIDTH{1'b1}};
            end else if (r_neg_lo) begin
                w_fin_lo = {WIDTH{1'b0}} - r_acc[WIDTH-1:0];
            end else begin
                w_fin_lo = r_acc[WIDTH-1:0];
            end
            if (r_neg_hi) begin
                w_fin_hi = {WIDTH{1'b0}} - r_acc[2*WIDTH-1:WIDTH];
            end else begin
                w_fin_hi = r_acc[2*WIDTH-1:WIDTH];
            end
        end else if (r_neg_lo) begin
            w_fin_hi = w_prod_neg[2*WIDTH-1:WIDTH];
            w_fin_lo = w_prod_neg[WIDTH-1:0];
        end else begin
            w_fin_hi = r_acc[2*WIDTH-1:WIDTH];
            w_fin_lo = r_acc[WIDTH-1:0];
        end
    end

    // Control FSM with registered outputs and the iterative datapath.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= {SHW{1'b0}};
            r_acc    <= {(2*WIDTH){1'b0}};
            r_opnd   <= {WIDTH{1'b0}};
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_is_div <= 1'b0;
            r_b_zero <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b0;
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_dz <= 1'b0;
                        case (i_op)
                            OP_MULTU, OP_MULT: begin
                                r_state  <= S_MUL;
                                r_busy   <= 1'b1;
                                r_done   <= 1'b0;
                                r_cnt    <= {SHW{1'b0}};
                                r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
                                r_opnd   <= w_a_mag;
                                r_neg_lo <= w_sign_diff;
                                r_neg_hi <= 1'b0;
                                r_is_div <= 1'b0;
                                r_b_zero <= 1'b0;
                            end
                            OP_DIVU, OP_DIV: begin
                                r_state  <= S_DIV;
                                r_busy   <= 1'b1;
                                r_done   <= 1'b0;
                                r_cnt    <= {SHW{1'b0}};
                                r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                                r_opnd   <= w_b_mag;
                                r_neg_lo <= w_sign_diff;
                                r_neg_hi <= w_signed_op && i_a[WIDTH-1];
                                r_is_div <= 1'b1;
                                r_b_zero <= (i_b == {WIDTH{1'b0}});
                            end
                            default: begin
                                r_result <= w_alu;
                                r_zero   <= (w_alu == {WIDTH{1'b0}});
                                r_done   <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_done <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + {{(SHW-1){1'b0}}, 1'b1};
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_state <= S_FIN;
                    end else begin
                        r_state <= S_MUL;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + {{(SHW-1){1'b0}}, 1'b1};
                    if (r_cnt == SHW'(WIDTH - 1)) begin
                        r_state <= S_FIN;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                S_FIN: begin
                    r_state  <= S_IDLE;
                    r_hi     <= w_fin_hi;
                    r_lo     <= w_fin_lo;
                    r_result <= w_fin_lo;
                    r_zero   <= (w_fin_lo == {WIDTH{1'b0}});
                    r_dz     <= r_is_div && r_b_zero;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
